pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline hazard and issue controller for the IF/ID/EX front end.
- Keeps a per-register pending-write scoreboard and stalls an instruction in ID while any source operand has an outstanding write.
- Sequences multi-cycle EX operations, including timeout detection.
- Squashes younger instructions on a taken branch and drives the IF/ID enables plus the EX bubble mux.

Parameters:
- N_REGS, 32, number of architectural registers; x0 is hardwired zero.
- RF_SIZE, $clog2(N_REGS), register index width.
- MC_TIMEOUT, 64, maximum cycles allowed in MC_WAIT before an error is flagged; must be ≥ 2.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  RF_SIZE  source register 1 of the ID instruction.
- id_rs2  in  RF_SIZE  source register 2 of the ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  RF_SIZE  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_is_mc  in  1  ID instruction is a multi-cycle EX operation.
- ex_branch_taken  in  1  branch in EX resolved as taken.
- mc_done  in  1  multi-cycle unit has finished (1-cycle pulse).
- wb_we  in  1  writeback is writing the register file.
- wb_rd  in  RF_SIZE  writeback destination register.
- if_en  out  1  IF/ID register enable.
- id_en  out  1  ID/EX register enable.
- ex_bubble  out  1  force a NOP into ID/EX (all control fields zero).
- flush  out  1  squash IF/ID contents.
- issue  out  1  ID instruction advances to EX this cycle.
- stall  out  1  ID hazard stall is active.
- mc_busy  out  1  FSM is in MC_WAIT or MC_ERR.
- mc_err  out  1  sticky multi-cycle timeout flag.
- stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: clock is clk; reset rst_n is asynchronous, active-low.
  - While asserted: busy[] = 0, state = RUN, timeout counter = 0, mc_err = 0, stall_cycles = 0.
  - While asserted: if_en = 0, id_en = 0, issue = 0, flush = 0, stall = 0, ex_bubble = 1, mc_busy = 0.
- Reset mid-operation discards all scoreboard state and any in-flight MC wait. No state survives reset.
- id_en = 1 whenever rst_n = 1. EX always loads, either the ID instruction or a bubble.
- Hazard, combinational:
  - haz1 = id_use_rs1 & (id_rs1 != 0) & busy[id_rs1].
  - haz2 is the same term for rs2.
  - x0 never hazards.
- A same-cycle WB clear does not unblock the reader. The clear takes effect next cycle, because the RF is not write-through.
- Priority, highest first:
  1. ex_branch_taken: flush = 1, ex_bubble = 1, issue = 0, if_en = 1, stall = 0. The squashed instruction never touches busy[]. FSM state is unchanged.
  2. state != RUN: stall = id_valid, ex_bubble = 1, issue = 0, if_en = 0.
  3. id_valid & (haz1 | haz2): stall = 1, ex_bubble = 1, issue = 0, if_en = 0.
  4. Otherwise: issue = id_valid, ex_bubble = ~id_valid, if_en = 1.
- Scoreboard, clocked:
  - Set busy[id_rd] when issue & id_reg_write & (id_rd != 0).
  - Clear busy[wb_rd] when wb_we & (wb_rd != 0).
  - Set and clear on the same index in the same cycle: set wins, because the newer producer is pending.
  - busy[0] is constant 0.
- FSM states: RUN, MC_WAIT, MC_ERR.
  - RUN → MC_WAIT on issue & id_is_mc; the timeout counter loads 0.
  - MC_WAIT: counter increments each cycle.
  - MC_WAIT → RUN on mc_done.
  - MC_WAIT → MC_ERR when counter == MC_TIMEOUT-1 without mc_done; mc_err is set.
  - MC_ERR → RUN on mc_done; mc_err stays set until reset.
  - mc_done in RUN is ignored.
- mc_done and issue of a new MC op cannot coincide, because issue is blocked outside RUN.
- stall_cycles increments when stall = 1 and saturates at all-ones.
- Latency: a consumer in ID sees its operand unblocked on the cycle after the producer's WB write.
- Back-to-back independent instructions issue every cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding localparams ST_RUN = 2'd0, ST_MC_WAIT = 2'd1, ST_MC_ERR = 2'd2;
  - the RF_SIZE derivation.
- One sub-module, pipe_scoreboard: busy vector, set/clear logic, and the two read ports haz1/haz2.
- The FSM, priority logic and counters live in pipe_ctrl.

Test Plan:
- Producer issues x5 (id_reg_write, rd = 5); next instr reads rs1 = 5 → stall = 1, ex_bubble = 1, if_en = 0 until the cycle after wb_we & wb_rd = 5, then issue = 1. stall_cycles equals the number of stall cycles.
- Instr reads x0 with busy vector all zero, and rd = 0 writes → never stall, busy[0] stays 0.
- Same cycle: issue with rd = 7 and wb_we with wb_rd = 7 → busy[7] = 1 afterwards, so a reader of x7 stalls.
- MC op issues, mc_done after 10 cycles → mc_busy high for exactly 10 cycles, issue = 0 throughout, then RUN and the next instr issues.
- MC op with no mc_done, MC_TIMEOUT = 64 → mc_err rises after 64 cycles in MC_WAIT. A later mc_done returns to RUN; mc_err stays 1.
- ex_branch_taken while the ID instr has a hazard → flush = 1, if_en = 1, issue = 0, busy unchanged. Asserting rst_n = 0 mid-MC_WAIT immediately clears state, busy[], mc_err and counters.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM encoding and register-index width helper for the pipeline controller.
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MC_WAIT = 2'd1;
  localparam logic [1:0] ST_MC_ERR  = 2'd2;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    MC_WAIT = ST_MC_WAIT,
    MC_ERR  = ST_MC_ERR
  } state_t;

  function automatic int rf_size(input int n_regs);
    return (n_regs > 1) ? $clog2(n_regs) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID/EX/WB handshake bundle between the pipeline datapath and the hazard controller.
`default_nettype none

interface pipe_ctrl_if
  import pipe_pkg::*;
#(
  parameter int RF_SIZE = rf_size(32),
  parameter int CNT_W   = 32
);
  logic               id_valid;
  logic [RF_SIZE-1:0] id_rs1;
  logic [RF_SIZE-1:0] id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [RF_SIZE-1:0] id_rd;
  logic               id_reg_write;
  logic               id_is_mc;
  logic               ex_branch_taken;
  logic               mc_done;
  logic               wb_we;
  logic [RF_SIZE-1:0] wb_rd;

  logic               if_en;
  logic               id_en;
  logic               ex_bubble;
  logic               flush;
  logic               issue;
  logic               stall;
  logic               mc_busy;
  logic               mc_err;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_is_mc, ex_branch_taken, mc_done, wb_we, wb_rd,
    input  if_en, id_en, ex_bubble, flush, issue, stall, mc_busy, mc_err, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_is_mc, ex_branch_taken, mc_done, wb_we, wb_rd,
    output if_en, id_en, ex_bubble, flush, issue, stall, mc_busy, mc_err, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register pending-write bits with two hazard read ports; x0 never pends.
`default_nettype none

module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int N_REGS  = 32,
  parameter int RF_SIZE = rf_size(N_REGS)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               set_en,
  input  wire logic [RF_SIZE-1:0] set_idx,
  input  wire logic               clr_en,
  input  wire logic [RF_SIZE-1:0] clr_idx,
  input  wire logic [RF_SIZE-1:0] rs1,
  input  wire logic               use_rs1,
  input  wire logic [RF_SIZE-1:0] rs2,
  input  wire logic               use_rs2,
  output logic                    haz1,
  output logic                    haz2
);

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_d;
  logic              hit1;
  logic              hit2;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < N_REGS; i++) begin
      if (clr_en && (clr_idx == RF_SIZE'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_idx == RF_SIZE'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Reads use the registered vector only: a same-cycle WB clear is not forwarded.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 1; i < N_REGS; i++) begin
      if (busy_q[i] && (rs1 == RF_SIZE'(i))) hit1 = 1'b1;
      if (busy_q[i] && (rs2 == RF_SIZE'(i))) hit2 = 1'b1;
    end
  end

  assign haz1 = use_rs1 & hit1;
  assign haz2 = use_rs2 & hit2;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: IF/ID/EX issue controller - RAW stalls, multi-cycle EX sequencing with timeout, branch squash.
`default_nettype none

module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int N_REGS     = 32,
  parameter int RF_SIZE    = rf_size(N_REGS),
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input wire logic   clk,
  input wire logic   rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int TO_W = $clog2(MC_TIMEOUT);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic haz1, haz2;
  logic if_en_c, flush_c, bubble_c, issue_c, stall_c;

  pipe_scoreboard #(
    .N_REGS  (N_REGS),
    .RF_SIZE (RF_SIZE)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue_c & bus.id_reg_write),
    .set_idx (bus.id_rd),
    .clr_en  (bus.wb_we),
    .clr_idx (bus.wb_rd),
    .rs1     (bus.id_rs1),
    .use_rs1 (bus.id_use_rs1),
    .rs2     (bus.id_rs2),
    .use_rs2 (bus.id_use_rs2),
    .haz1    (haz1),
    .haz2    (haz2)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if_en_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b1;
    issue_c  = 1'b0;
    stall_c  = 1'b0;

    if (rst_n) begin
      if (bus.ex_branch_taken) begin
        flush_c = 1'b1;
        if_en_c = 1'b1;
      end else if (state_q != RUN) begin
        stall_c = bus.id_valid;
      end else if (bus.id_valid && (haz1 || haz2)) begin
        stall_c = 1'b1;
      end else begin
        issue_c  = bus.id_valid;
        bubble_c = ~bus.id_valid;
        if_en_c  = 1'b1;
      end
    end

    case (state_q)
      RUN: begin
        if (issue_c && bus.id_is_mc) begin
          state_d = MC_WAIT;
          cnt_d   = '0;
        end
      end
      MC_WAIT: begin
        if (bus.mc_done) begin
          state_d = RUN;
        end else if (cnt_q == TO_W'(MC_TIMEOUT - 1)) begin
          state_d = MC_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MC_ERR: begin
        if (bus.mc_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.if_en        = if_en_c;
  assign bus.id_en        = rst_n;
  assign bus.ex_bubble    = bubble_c;
  assign bus.flush        = flush_c;
  assign bus.issue        = issue_c;
  assign bus.stall        = stall_c;
  assign bus.mc_busy      = rst_n & (state_q != RUN);
  assign bus.mc_err       = err_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
`default_nettype none

module tb_pipe_ctrl;

  localparam int NR   = 32;
  localparam int RW   = 5;
  localparam int TO   = 64;
  localparam int CW   = 8;
  localparam int SMAX = 255;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pipe_ctrl_if #(.RF_SIZE(RW), .CNT_W(CW)) bus ();

  pipe_ctrl #(
    .N_REGS     (NR),
    .RF_SIZE    (RW),
    .MC_TIMEOUT (TO),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, multi-cycle phase tracking, stall tally.
  bit busy_m [NR];
  bit mc_on, waiting, err_m;
  int mc_age, stalls_m;
  bit e_if, e_bub, e_fl, e_iss, e_st, haz;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_en", bus.if_en, 0);
      chk("rst_id_en", bus.id_en, 0);
      chk("rst_issue", bus.issue, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_bubble", bus.ex_bubble, 1);
      chk("rst_mc_busy", bus.mc_busy, 0);
      chk("rst_mc_err", bus.mc_err, 0);
      chk("rst_stall_cycles", 32'(bus.stall_cycles), 0);
      foreach (busy_m[i]) busy_m[i] = 0;
      mc_on = 0; waiting = 0; err_m = 0; mc_age = 0; stalls_m = 0;
    end else begin
      haz = (bus.id_use_rs1 && bus.id_rs1 != 0 && busy_m[bus.id_rs1]) ||
            (bus.id_use_rs2 && bus.id_rs2 != 0 && busy_m[bus.id_rs2]);
      e_if = 0; e_bub = 1; e_fl = 0; e_iss = 0; e_st = 0;
      if (bus.ex_branch_taken) begin
        e_fl = 1; e_if = 1;
      end else if (mc_on) begin
        e_st = bus.id_valid;
      end else if (bus.id_valid && haz) begin
        e_st = 1;
      end else begin
        e_iss = bus.id_valid; e_bub = !bus.id_valid; e_if = 1;
      end
      chk("if_en", bus.if_en, e_if);
      chk("id_en", bus.id_en, 1);
      chk("ex_bubble", bus.ex_bubble, e_bub);
      chk("flush", bus.flush, e_fl);
      chk("issue", bus.issue, e_iss);
      chk("stall", bus.stall, e_st);
      chk("mc_busy", bus.mc_busy, mc_on);
      chk("mc_err", bus.mc_err, err_m);
      chk("stall_cycles", 32'(bus.stall_cycles), stalls_m);
      // advance the model to the next cycle
      if (bus.wb_we && bus.wb_rd != 0) busy_m[bus.wb_rd] = 0;
      if (e_iss && bus.id_reg_write && bus.id_rd != 0) busy_m[bus.id_rd] = 1;
      if (!mc_on) begin
        if (e_iss && bus.id_is_mc) begin mc_on = 1; waiting = 1; mc_age = 0; end
      end else if (waiting) begin
        if (bus.mc_done) mc_on = 0;
        else begin
          mc_age++;
          if (mc_age == TO) begin waiting = 0; err_m = 1; end
        end
      end else if (bus.mc_done) begin
        mc_on = 0;
      end
      if (e_st && stalls_m != SMAX) stalls_m++;
    end
  end

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_rd = 0; bus.id_reg_write = 0; bus.id_is_mc = 0; bus.ex_branch_taken = 0;
    bus.mc_done = 0; bus.wb_we = 0; bus.wb_rd = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int n_busy, n_iss, n;

  initial begin
    checks = 0; failures = 0;
    rst_n = 0;
    idle();
    repeat (3) nxt();
    chk("lit_reset_bubble", bus.ex_bubble, 1);
    chk("lit_reset_cnt", 32'(bus.stall_cycles), 0);
    rst_n = 1;

    // RAW on x5: stall until the cycle after WB
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 5;
    @(negedge clk); chk("lit_prod_issue", bus.issue, 1); nxt();
    idle(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 5;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin bus.wb_we = 1; bus.wb_rd = 5; end
      @(negedge clk);
      chk("lit_raw_stall", bus.stall, 1);
      chk("lit_raw_if_en", bus.if_en, 0);
      chk("lit_raw_bubble", bus.ex_bubble, 1);
      nxt();
    end
    bus.wb_we = 0;
    @(negedge clk); chk("lit_raw_release", bus.issue, 1); chk("lit_stall_cnt3", 32'(bus.stall_cycles), 3); nxt();

    // x0 is never pending
    idle(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_use_rs2 = 1; bus.id_reg_write = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("lit_x0_issue", bus.issue, 1); nxt();
    end

    // same-cycle set and clear of x7: set wins
    idle(); bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 7; bus.wb_we = 1; bus.wb_rd = 7;
    @(negedge clk); chk("lit_x7_issue", bus.issue, 1); nxt();
    idle(); bus.id_valid = 1; bus.id_use_rs2 = 1; bus.id_rs2 = 7;
    @(negedge clk); chk("lit_x7_stall", bus.stall, 1); nxt();
    bus.wb_we = 1; bus.wb_rd = 7; nxt();
    bus.wb_we = 0;
    @(negedge clk); chk("lit_x7_release", bus.issue, 1); nxt();

    // multi-cycle op completing after 10 cycles
    idle(); bus.id_valid = 1; bus.id_is_mc = 1;
    @(negedge clk); chk("lit_mc_issue", bus.issue, 1); nxt();
    idle(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 1;
    n_busy = 0; n_iss = 0;
    for (int k = 1; k <= 10; k++) begin
      bus.mc_done = (k == 10);
      @(negedge clk); n_busy += int'(bus.mc_busy); n_iss += int'(bus.issue); nxt();
    end
    bus.mc_done = 0;
    chk("lit_mc_busy_cycles", n_busy, 10);
    chk("lit_mc_no_issue", n_iss, 0);
    @(negedge clk); chk("lit_mc_after_issue", bus.issue, 1); nxt();

    // timeout: no mc_done
    idle(); bus.id_valid = 1; bus.id_is_mc = 1; nxt();
    idle(); n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.mc_err) break;
      n += int'(bus.mc_busy);
      nxt();
    end
    chk("lit_timeout_cycles", n, 64);
    nxt();
    bus.mc_done = 1; nxt();
    bus.mc_done = 0;
    @(negedge clk); chk("lit_err_run", bus.mc_busy, 0); chk("lit_err_sticky", bus.mc_err, 1); nxt();

    // branch squash over a hazarded instruction
    idle(); bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 3; nxt();
    idle(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 3; bus.id_reg_write = 1; bus.id_rd = 9;
    bus.ex_branch_taken = 1;
    @(negedge clk);
    chk("lit_br_flush", bus.flush, 1); chk("lit_br_if_en", bus.if_en, 1); chk("lit_br_issue", bus.issue, 0);
    nxt();
    bus.ex_branch_taken = 0; bus.id_reg_write = 0;
    @(negedge clk); chk("lit_br_busy_kept", bus.stall, 1); nxt();
    bus.wb_we = 1; bus.wb_rd = 3; nxt();
    idle(); bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 9;
    @(negedge clk); chk("lit_br_no_set", bus.issue, 1); nxt();

    // reset in the middle of MC_WAIT
    idle(); bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 4; nxt();
    idle(); bus.id_valid = 1; bus.id_is_mc = 1; nxt();
    idle(); repeat (5) nxt();
    rst_n = 0; #1;
    chk("lit_arst_busy", bus.mc_busy, 0); chk("lit_arst_err", bus.mc_err, 0);
    chk("lit_arst_cnt", 32'(bus.stall_cycles), 0); chk("lit_arst_if_en", bus.if_en, 0);
    nxt();
    rst_n = 1; bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 4;
    @(negedge clk); chk("lit_arst_sb_clear", bus.issue, 1); nxt();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom % 1000) != 0;
      bus.id_valid        = ($urandom % 4) != 0;
      bus.id_rs1          = RW'($urandom % 8);
      bus.id_rs2          = RW'($urandom % 8);
      bus.id_use_rs1      = $urandom % 2;
      bus.id_use_rs2      = $urandom % 2;
      bus.id_rd           = RW'($urandom % 8);
      bus.id_reg_write    = ($urandom % 3) != 0;
      bus.id_is_mc        = ($urandom % 15) == 0;
      bus.ex_branch_taken = ($urandom % 12) == 0;
      bus.mc_done         = ($urandom % 12) == 0;
      bus.wb_we           = ($urandom % 3) == 0;
      bus.wb_rd           = RW'($urandom % 8);
      nxt();
    end
    rst_n = 1;
    idle();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
